// File: rtl/mem_cfg_responder.sv
// Register-bank responder for the switch memory/configuration interface.
// Holds per-port address registers plus CTRL, and answers each request with a one-cycle ack.
module mem_cfg_responder #(
  parameter int          NUM_PORTS     = 4,
  parameter int          WAIT_CYCLES   = 1,
  parameter logic [7:0]  ID_VALUE      = 8'h5A,
  parameter logic [7:0]  PORT_ADDR_RST = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_sel_en,
  input  logic [7:0]             mem_addr,
  input  logic [7:0]             mem_wr_data,
  input  logic                   mem_wr_rd_s,
  output logic [7:0]             mem_rd_data,
  output logic                   mem_ack,
  output logic                   mem_err,
  output logic [8*NUM_PORTS-1:0] port_addr_o,
  output logic                   sw_en_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [7:0] ADDR_CTRL   = 8'h0F;
  localparam logic [7:0] ADDR_ID     = 8'h10;
  localparam logic [7:0] PORT_LIMIT  = 8'(NUM_PORTS);
  localparam int         IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0] WAIT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]       state;
  logic [3:0]       wait_cnt;
  logic [7:0]       req_addr;
  logic [7:0]       req_data;
  logic             req_wr;
  logic [7:0]       port_reg [NUM_PORTS];
  logic             ctrl_en;

  logic             hit_port;
  logic [IDX_W-1:0] port_idx;
  logic [7:0]       rd_value;
  logic             illegal;

  assign hit_port = (req_addr < PORT_LIMIT);
  assign port_idx = req_addr[IDX_W-1:0];

  // Decode the latched request: the read value and whether the access is illegal.
  always_comb begin
    rd_value = 8'h00;
    illegal  = 1'b0;
    if (hit_port) begin
      rd_value = port_reg[port_idx];
    end else if (req_addr == ADDR_CTRL) begin
      rd_value = {7'b0, ctrl_en};
    end else if (req_addr == ADDR_ID) begin
      rd_value = ID_VALUE;
      illegal  = req_wr;
    end else begin
      illegal  = 1'b1;
    end
  end

  // The ACK state performs the access; ack/err/rd_data are registered so they appear the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      req_addr    <= 8'h00;
      req_data    <= 8'h00;
      req_wr      <= 1'b0;
      mem_ack     <= 1'b0;
      mem_err     <= 1'b0;
      mem_rd_data <= 8'h00;
      ctrl_en     <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        port_reg[i] <= PORT_ADDR_RST;
      end
    end else begin
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_sel_en) begin
            req_addr <= mem_addr;
            req_data <= mem_wr_data;
            req_wr   <= mem_wr_rd_s;
            if (WAIT_CYCLES > 0) begin
              wait_cnt <= WAIT_LOAD;
              state    <= ST_WAIT;
            end else begin
              state    <= ST_ACK;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          mem_ack <= 1'b1;
          mem_err <= illegal;
          if (req_wr) begin
            if (hit_port) begin
              port_reg[port_idx] <= req_data;
            end else if (req_addr == ADDR_CTRL) begin
              ctrl_en <= req_data[0];
            end
          end else begin
            mem_rd_data <= rd_value;
          end
          state <= mem_sel_en ? ST_RELEASE : ST_IDLE;
        end
        ST_RELEASE: begin
          if (!mem_sel_en) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_out
    assign port_addr_o[8*g +: 8] = port_reg[g];
  end

  assign sw_en_o = ctrl_en;

endmodule
